// File: rtl/dec_cs_seq.sv
// Registered one-hot chip-select sequencer: latches a select code and a wait count, then holds one cs for wait+1 cycles and acks.
// Optional macro DEC_CS_ACTIVE_LOW_EN makes cs active-low (74x138 sense); busy/ack/err stay active-high.
module dec_cs_seq #(
    parameter int unsigned SEL_W  = 5,
    parameter int unsigned N_OUT  = 32,
    parameter int unsigned WAIT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [SEL_W-1:0]  sel,
    input  logic [WAIT_W-1:0] wait_cyc,
    input  logic              abort,
    output logic [N_OUT-1:0]  cs,
    output logic              busy,
    output logic              ack,
    output logic              err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

`ifdef DEC_CS_ACTIVE_LOW_EN
    localparam logic [N_OUT-1:0] CS_OFF = '1;
`else
    localparam logic [N_OUT-1:0] CS_OFF = '0;
`endif

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [N_OUT-1:0]  cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [N_OUT-1:0]  dec_c;
    logic              sel_ok_c;

    // One-hot decode of the incoming select code (active-high internally)
    always_comb begin
        dec_c = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (sel == SEL_W'(i)) begin
                dec_c[i] = 1'b1;
            end
        end
    end

    assign sel_ok_c = ({1'b0, sel} < (SEL_W+1)'(N_OUT));

    // State and registered outputs; reset drops cs asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cs_q    <= CS_OFF;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next state plus next output values; outputs reflect the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = CS_OFF;
        busy_d  = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (sel_ok_c) begin
                        state_d = S_ACTIVE;
                        cnt_d   = wait_cyc;
                        cs_d    = dec_c ^ CS_OFF;
                        busy_d  = 1'b1;
                        ack_d   = (wait_cyc == '0);
                    end else begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                busy_d = 1'b1;
                if (abort) begin
                    // abort sampled on the edge that would raise ack suppresses it
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                    cs_d  = cs_q;
                    ack_d = (cnt_q == WAIT_W'(1));
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cs   = cs_q;
    assign busy = busy_q;
    assign ack  = ack_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dec_cs_seq.sv
// Directed table-driven bench for dec_cs_seq, plus hand sequences for reset, out-of-range select and reset mid-access.
module tb_dec_cs_seq;

`ifdef DEC_CS_ACTIVE_LOW_EN
    localparam logic [31:0] OFF32 = 32'hFFFF_FFFF;
    localparam logic [19:0] OFF20 = 20'hF_FFFF;
`else
    localparam logic [31:0] OFF32 = 32'h0;
    localparam logic [19:0] OFF20 = 20'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [4:0]  sel = '0;
    logic [2:0]  wait_cyc = '0;
    logic        abort = 1'b0;
    logic [31:0] cs;
    logic        busy, ack, err;

    logic        req2 = 1'b0;
    logic [4:0]  sel2 = '0;
    logic [2:0]  wait2 = '0;
    logic        abort2 = 1'b0;
    logic [19:0] cs2;
    logic        busy2, ack2, err2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dec_cs_seq #(.SEL_W(5), .N_OUT(32), .WAIT_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .wait_cyc(wait_cyc),
        .abort(abort), .cs(cs), .busy(busy), .ack(ack), .err(err)
    );

    dec_cs_seq #(.SEL_W(5), .N_OUT(20), .WAIT_W(3)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .req(req2), .sel(sel2), .wait_cyc(wait2),
        .abort(abort2), .cs(cs2), .busy(busy2), .ack(ack2), .err(err2)
    );

    typedef struct {
        logic       req;
        logic [4:0] sel;
        logic [2:0] wc;
        logic       abort;
        int         cs_idx;
        logic       busy;
        logic       ack;
        logic       err;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, int s, int w, logic a, int ci, logic b, logic k);
        vec_t v;
        v.req = r; v.sel = 5'(s); v.wc = 3'(w); v.abort = a;
        v.cs_idx = ci; v.busy = b; v.ack = k; v.err = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] exp32(int idx);
        logic [31:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v ^ OFF32;
    endfunction

    function automatic logic [19:0] exp20(int idx);
        logic [19:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v ^ OFF20;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string name, input int ci, input logic b, input logic k, input logic e);
        chk({name, ".cs"}, cs, exp32(ci));
        chk({name, ".busy"}, 32'(busy), 32'(b));
        chk({name, ".ack"}, 32'(ack), 32'(k));
        chk({name, ".err"}, 32'(err), 32'(e));
        chk({name, ".onehot"}, 32'($countones(cs ^ OFF32) <= 1), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // test 2: sel=5, wait 0
        vecs[0]  = mk(1, 5, 0, 0,  5, 1, 1);
        vecs[1]  = mk(0, 0, 0, 0, -1, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, -1, 0, 0);
        // test 3: sel=31, wait 7, inputs toggled mid-access, req while busy ignored
        vecs[3]  = mk(1, 31, 7, 0, 31, 1, 0);
        vecs[4]  = mk(0, 4, 1, 0, 31, 1, 0);
        vecs[5]  = mk(1, 2, 0, 0, 31, 1, 0);
        vecs[6]  = mk(1, 2, 0, 0, 31, 1, 0);
        vecs[7]  = mk(0, 17, 3, 0, 31, 1, 0);
        vecs[8]  = mk(0, 0, 6, 0, 31, 1, 0);
        vecs[9]  = mk(0, 9, 2, 0, 31, 1, 0);
        vecs[10] = mk(0, 1, 0, 0, 31, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, -1, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, -1, 0, 0);
        // test 5a: sel=3, wait 4, abort sampled at the edge starting cs cycle 5
        vecs[13] = mk(1, 3, 4, 0,  3, 1, 0);
        vecs[14] = mk(0, 0, 0, 0,  3, 1, 0);
        vecs[15] = mk(0, 0, 0, 0,  3, 1, 0);
        vecs[16] = mk(0, 0, 0, 0,  3, 1, 0);
        vecs[17] = mk(0, 0, 0, 1, -1, 1, 0);
        vecs[18] = mk(0, 0, 0, 0, -1, 0, 0);
        // test 5b: abort at cs cycle 2
        vecs[19] = mk(1, 3, 4, 0,  3, 1, 0);
        vecs[20] = mk(0, 0, 0, 1, -1, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, -1, 0, 0);
        // abort in IDLE ignored, then sel=0 wait 1
        vecs[22] = mk(0, 0, 0, 1, -1, 0, 0);
        vecs[23] = mk(1, 0, 1, 0,  0, 1, 0);
        vecs[24] = mk(0, 0, 0, 0,  0, 1, 1);
        vecs[25] = mk(0, 0, 0, 0, -1, 1, 0);
        vecs[26] = mk(0, 0, 0, 0, -1, 0, 0);

        // reset held with req asserted
        req = 1'b1; sel = 5'd5;
        repeat (3) @(posedge clk);
        #1 chk_main("reset", -1, 0, 0, 0);
        @(negedge clk) req = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_main("post_reset", -1, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req = vecs[i].req; sel = vecs[i].sel; wait_cyc = vecs[i].wc; abort = vecs[i].abort;
            @(posedge clk);
            #1 chk_main($sformatf("vec%0d", i), vecs[i].cs_idx, vecs[i].busy, vecs[i].ack, vecs[i].err);
        end
        @(negedge clk) begin req = 1'b0; abort = 1'b0; end

        // out-of-range select on N_OUT=20 instance
        @(negedge clk) begin req2 = 1'b1; sel2 = 5'd25; wait2 = 3'd2; end
        @(posedge clk);
        #1;
        chk("oor.err", 32'(err2), 32'd1);
        chk("oor.ack", 32'(ack2), 32'd1);
        chk("oor.busy", 32'(busy2), 32'd0);
        chk("oor.cs", 32'(cs2), 32'(exp20(-1)));
        @(negedge clk) req2 = 1'b0;
        @(posedge clk);
        #1;
        chk("oor2.err", 32'(err2), 32'd0);
        chk("oor2.ack", 32'(ack2), 32'd0);
        chk("oor2.cs", 32'(cs2), 32'(exp20(-1)));
        // highest legal select on the narrow instance
        @(negedge clk) begin req2 = 1'b1; sel2 = 5'd19; wait2 = 3'd0; end
        @(posedge clk);
        #1;
        chk("top20.cs", 32'(cs2), 32'(exp20(19)));
        chk("top20.ack", 32'(ack2), 32'd1);
        chk("top20.err", 32'(err2), 32'd0);
        @(negedge clk) req2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("top20.idle", 32'(busy2), 32'd0);

        // reset in the 3rd ACTIVE cycle
        @(negedge clk) begin req = 1'b1; sel = 5'd3; wait_cyc = 3'd4; end
        @(posedge clk);
        #1 chk_main("rst_mid.c1", 3, 1, 0, 0);
        @(negedge clk) req = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_main("rst_mid.c3", 3, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1 chk_main("rst_mid.async", -1, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1 chk_main("rst_mid.hold", -1, 0, 0, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 chk_main("rst_mid.after", -1, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
